ifetch_queue: RTL

Instruction queue between `ifetch` and decode. Buffers fetched instruction words with their PC, MSR and fault code so short decode stalls do not back-pressure the I-side fetch pipe, and so an in-flight fetch has somewhere to land when decode stalls. Flushes on annul or redirect. Uses the same valid/stall handshake as the existing `ifetch` → decode path.

---
 rtl/ifetch_queue_pkg.sv | 34 +++
 rtl/ifq_storage.sv | 45 ++++
 rtl/ifetch_queue.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction queue between ifetch and decode.
// Purpose : fault-code width, the "no fault" code, and the layout of one
//           queued entry ({instr, pc, msr, fault}, 100 bits).
// Ports   : none (package).
package ifetch_queue_pkg;

    localparam int FAULT_W = 4;
    localparam logic [FAULT_W-1:0] FAULT_NONE = '0;

    localparam int WORD_W  = 32;
    localparam int ENTRY_W = WORD_W + WORD_W + WORD_W + FAULT_W;

    typedef struct packed {
        logic [WORD_W-1:0]  instr;
        logic [WORD_W-1:0]  pc;
        logic [WORD_W-1:0]  msr;
        logic [FAULT_W-1:0] fault;
    } ifq_entry_t;

    function automatic ifq_entry_t make_entry(
        input logic [WORD_W-1:0]  instr,
        input logic [WORD_W-1:0]  pc,
        input logic [WORD_W-1:0]  msr,
        input logic [FAULT_W-1:0] fault
    );
        ifq_entry_t e;
        e.instr = instr;
        e.pc    = pc;
        e.msr   = msr;
        e.fault = fault;
        return e;
    endfunction

endpackage

// File: rtl/ifq_storage.sv
// Entry storage for ifetch_queue.
// Purpose : DEPTH x ENTRY_W flop array with one synchronous write port and
//           one asynchronous (combinational) read port. Kept as flops rather
//           than RAM so the head entry is visible in the same cycle the read
//           pointer moves. Contents are not reset.
// Ports   : clk      - clock
//           wr_en    - write strobe
//           wr_addr  - write slot
//           wr_data  - entry to store
//           rd_addr  - read slot
//           rd_data  - entry at rd_addr (combinational)
import ifetch_queue_pkg::*;

module ifq_storage #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  ifq_entry_t        wr_data,
    input  logic [AW-1:0]     rd_addr,
    output ifq_entry_t        rd_data
);

    ifq_entry_t slots [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            ifq_entry_t slot_reg;

            always_ff @(posedge clk) begin
                if (wr_en && (wr_addr == AW'(gi))) begin
                    slot_reg <= wr_data;
                end
            end

            assign slots[gi] = slot_reg;
        end
    endgenerate

    assign rd_data = slots[rd_addr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction queue between ifetch and decode.
// Purpose : buffers fetched words (instr, pc, msr, fault) so short decode
//           stalls do not back-pressure fetch. Valid/stall handshake on both
//           sides, flush on annul/redirect, and a sticky hold after a
//           faulting fetch until the next flush.
// Ports   : clk        - clock, all state on rising edge
//           reset      - asynchronous active-low reset
//           in_valid/in_instr/in_pc/in_msr/in_fault - from ifetch
//           in_stall   - back-pressure to ifetch (registered-only source)
//           flush      - drop everything; takes effect next cycle
//           out_valid/out_instr/out_pc/out_msr/out_fault - head entry to decode
//           out_stall  - decode stall
//           count      - occupancy 0..DEPTH
import ifetch_queue_pkg::*;

module ifetch_queue #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [31:0]        in_instr,
    input  logic [31:0]        in_pc,
    input  logic [31:0]        in_msr,
    input  logic [FAULT_W-1:0] in_fault,
    output logic               in_stall,
    input  logic               flush,
    output logic               out_valid,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_msr,
    output logic [FAULT_W-1:0] out_fault,
    input  logic               out_stall,
    output logic [AW:0]        count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg,  count_next;
    logic          fault_held_reg, fault_held_next;

    logic       push;
    logic       pop;
    ifq_entry_t wr_entry;
    ifq_entry_t head_entry;

    // in_stall depends only on registers, so a full queue refuses a push
    // even when a pop happens in the same cycle (one bubble, by design).
    assign in_stall  = (count_reg == FULL_COUNT) || fault_held_reg;
    assign out_valid = (count_reg != '0) && !flush;

    // A push offered in a flush cycle is discarded.
    assign push = in_valid && !in_stall && !flush;
    assign pop  = out_valid && !out_stall;

    assign wr_entry = make_entry(in_instr, in_pc, in_msr, in_fault);

    ifq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_reg),
        .rd_data (head_entry)
    );

    assign out_instr = head_entry.instr;
    assign out_pc    = head_entry.pc;
    assign out_msr   = head_entry.msr;
    assign out_fault = head_entry.fault;
    assign count     = count_reg;

    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        fault_held_next = fault_held_reg;

        if (flush) begin
            wr_ptr_next     = '0;
            rd_ptr_next     = '0;
            count_next      = '0;
            fault_held_next = 1'b0;
        end else begin
            // Pointers are AW bits wide and wrap on their own; full/empty
            // are always decided from count, never from pointer equality.
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
            // Fetch after a fault is meaningless until redirect: hold off
            // further pushes. The faulting entry itself still drains in order.
            if (push && (in_fault != FAULT_NONE)) begin
                fault_held_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            fault_held_reg <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            fault_held_reg <= fault_held_next;
        end
    end

endmodule
